// File: rtl/imm_decode_ctrl.sv
// Registered opcode decode in a two-entry skid buffer: 1-cycle accept->out_valid, registered in_ready drops only when both entries are full.
// IMM_ILLEGAL_TRAP_EN: illegal opcodes are dropped at accept and raise a one-cycle illegal_trap instead of being buffered.
module imm_decode_ctrl #(
    parameter int IWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IWIDTH-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IWIDTH-8:0] out_inst,
    output logic [2:0]        out_immsel,
    output logic              out_imm_used,
    output logic              out_illegal,
    output logic              illegal_trap,
    output logic [15:0]       stall_cnt
);

    if (DWIDTH != IWIDTH) begin : g_width_check
        $error("imm_decode_ctrl: DWIDTH must equal IWIDTH");
    end

    typedef struct packed {
        logic [IWIDTH-8:0] inst;
        logic [2:0]        sel;
        logic              used;
        logic              ill;
    } ent_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t      state_q, state_d;
    ent_t        main_q, main_d, skid_q, skid_d, dec;
    logic        in_ready_q, trap_q, trap_d;
    logic [15:0] stall_q, stall_d;
    logic        acc, fire, drop;
    logic        load_main, load_skid, shift;

    always_comb begin
        dec      = '0;
        dec.inst = in_inst[IWIDTH-1:7];
        dec.used = 1'b1;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0001111, 7'b1110011:             dec.sel = 3'b000;
            7'b0100011:                         dec.sel = 3'b001;
            7'b1100011:                         dec.sel = 3'b010;
            7'b0110111, 7'b0010111:             dec.sel = 3'b011;
            7'b1101111:                         dec.sel = 3'b100;
            7'b0110011: begin
                dec.sel  = 3'b000;
                dec.used = 1'b0;
            end
            default: begin
                dec.sel  = 3'b111;
                dec.used = 1'b0;
                dec.ill  = 1'b1;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_TRAP_EN
    assign drop   = dec.ill;
    assign trap_d = in_valid & in_ready_q & dec.ill & ~flush;
`else
    assign drop   = 1'b0;
    assign trap_d = 1'b0;
`endif

    // An illegal instruction under trap mode is consumed but never buffered.
    assign acc     = in_valid & in_ready_q & ~drop;
    assign fire    = (state_q != S_EMPTY) & out_ready;
    assign stall_d = ((state_q != S_EMPTY) && !out_ready && stall_q != 16'hFFFF)
                     ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b0;
            trap_q     <= 1'b0;
            stall_q    <= '0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
            trap_q     <= trap_d;
            stall_q    <= stall_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (acc) begin
                    load_main = 1'b1;
                    state_d   = S_ONE;
                end
                S_ONE: begin
                    if (acc && fire) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        load_skid = 1'b1;
                        state_d   = S_TWO;
                    end else if (fire) begin
                        state_d   = S_EMPTY;
                    end
                end
                S_TWO: if (fire) begin
                    shift   = 1'b1;
                    state_d = S_ONE;
                end
                default: state_d = S_EMPTY;
            endcase
        end
        main_d = main_q;
        skid_d = skid_q;
        if (load_main)  main_d = dec;
        else if (shift) main_d = skid_q;
        if (load_skid)  skid_d = dec;
    end

    // Stale main contents are masked so EMPTY always presents zeros.
    always_comb begin
        out_valid    = (state_q != S_EMPTY);
        in_ready     = in_ready_q;
        out_inst     = out_valid ? main_q.inst : '0;
        out_immsel   = out_valid ? main_q.sel  : 3'b000;
        out_imm_used = out_valid & main_q.used;
`ifdef IMM_ILLEGAL_TRAP_EN
        out_illegal  = 1'b0;
`else
        out_illegal  = out_valid & main_q.ill;
`endif
        illegal_trap = trap_q;
        stall_cnt    = stall_q;
    end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Randomized and directed checks of imm_decode_ctrl against a queue-based reference model.
module tb_imm_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [24:0] out_inst;
    logic [2:0]  out_immsel;
    logic        out_imm_used, out_illegal, illegal_trap;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    imm_decode_ctrl #(.IWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_immsel(out_immsel),
        .out_imm_used(out_imm_used), .out_illegal(out_illegal),
        .illegal_trap(illegal_trap), .stall_cnt(stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ordered list of buffered instructions plus registered flags.
    logic [31:0] mq[$];
    bit          m_rdy;
    int          m_stall;
    bit          m_trap;

`ifdef IMM_ILLEGAL_TRAP_EN
    localparam bit TRAP_MODE = 1'b1;
`else
    localparam bit TRAP_MODE = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {immsel, imm_used, illegal} for an instruction.
    function automatic logic [4:0] ref_dec(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return {3'd0, 1'b1, 1'b0};
            7'h23:                             return {3'd1, 1'b1, 1'b0};
            7'h63:                             return {3'd2, 1'b1, 1'b0};
            7'h37, 7'h17:                      return {3'd3, 1'b1, 1'b0};
            7'h6F:                             return {3'd4, 1'b1, 1'b0};
            7'h33:                             return {3'd0, 1'b0, 1'b0};
            default:                           return {3'd7, 1'b0, 1'b1};
        endcase
    endfunction

    task automatic check_all();
        logic [4:0]  d;
        logic [31:0] head;
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            head = mq[0];
            d    = ref_dec(head);
            chk("out_inst", 32'(out_inst), {7'b0, head[31:7]});
            chk("out_immsel", 32'(out_immsel), 32'(d[4:2]));
            chk("out_imm_used", 32'(out_imm_used), 32'(d[1]));
            chk("out_illegal", 32'(out_illegal), TRAP_MODE ? 32'd0 : 32'(d[0]));
        end else begin
            chk("idle_inst", 32'(out_inst), 32'd0);
            chk("idle_immsel", 32'(out_immsel), 32'd0);
            chk("idle_imm_used", 32'(out_imm_used), 32'd0);
            chk("idle_illegal", 32'(out_illegal), 32'd0);
        end
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("illegal_trap", 32'(illegal_trap), 32'(m_trap));
    endtask

    // Called at a falling edge with inputs already driven; advances one clock and checks.
    task automatic cycle();
        bit         acc, fire, ill;
        logic [4:0] d;
        if (rst) begin
            mq.delete();
            m_rdy   = 1'b0;
            m_stall = 0;
            m_trap  = 1'b0;
        end else begin
            d    = ref_dec(in_inst);
            ill  = d[0];
            acc  = in_valid && m_rdy;
            fire = (mq.size() > 0) && out_ready;
            if (mq.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
            m_trap = acc && ill && TRAP_MODE && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (fire) void'(mq.pop_front());
                if (acc && !(ill && TRAP_MODE)) mq.push_back(in_inst);
            end
            m_rdy = (mq.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SW   = 32'h00112223;
    localparam logic [31:0] LUI  = 32'h123450B7;

    logic [31:0] seq     [5] = '{32'h00112223, 32'h00208463, 32'h123450B7, 32'h008000EF, 32'h002081B3};
    logic [2:0]  seq_sel [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic        seq_used[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0]  ops[12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        chk("rst_release_rdy", 32'(in_ready), 32'd1);

        // Single addi: one-cycle latency, I-format.
        in_valid = 1'b1; in_inst = ADDI; out_ready = 1'b1;
        cycle();
        chk("addi_vld", 32'(out_valid), 32'd1);
        chk("addi_sel", 32'(out_immsel), 32'd0);
        chk("addi_used", 32'(out_imm_used), 32'd1);
        chk("addi_inst", 32'(out_inst), 32'h0000A001);

        // Back-to-back formats at full throughput.
        for (int i = 0; i < 5; i++) begin
            in_inst = seq[i];
            cycle();
            chk("seq_sel", 32'(out_immsel), 32'(seq_sel[i]));
            chk("seq_used", 32'(out_imm_used), 32'(seq_used[i]));
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Backpressure: three offered, two held, order preserved.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = ADDI; cycle();
        in_inst = SW;   cycle();
        in_inst = LUI;  cycle();
        cycle();
        chk("full_rdy", 32'(in_ready), 32'd0);
        chk("hold_inst", 32'(out_inst), {7'b0, ADDI[31:7]});
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("order_second", 32'(out_inst), {7'b0, SW[31:7]});
        cycle();
        chk("drained", 32'(out_valid), 32'd0);

        // Flush from the full state.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = ADDI; cycle();
        in_inst = SW;   cycle();
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_vld", 32'(out_valid), 32'd0);
        chk("flush_rdy", 32'(in_ready), 32'd1);

        // Illegal opcode.
        in_valid = 1'b1; in_inst = 32'h0000007F;
        cycle();
        in_valid = 1'b0;
`ifdef IMM_ILLEGAL_TRAP_EN
        chk("ill_trap", 32'(illegal_trap), 32'd1);
        chk("ill_vld", 32'(out_valid), 32'd0);
        cycle();
        chk("ill_trap_end", 32'(illegal_trap), 32'd0);
`else
        chk("ill_vld", 32'(out_valid), 32'd1);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_sel", 32'(out_immsel), 32'd7);
`endif
        out_ready = 1'b1;
        cycle();

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            in_inst   = {$urandom, 7'b0} | 32'(ops[$urandom_range(0, 11)]);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        // Stall counter saturation.
        in_valid = 1'b1; in_inst = ADDI; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        repeat (66000) cycle();
        chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
        cycle();
        chk("stall_sat_hold", 32'(stall_cnt), 32'h0000FFFF);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
